// File: rtl/wfg_drive_pwm.sv
`default_nettype none
// ============================================================================
// Module      : wfg_drive_pwm
// Description : Turns each 32-bit AXI-Stream sample into the duty cycle of one
//               PWM period on pwm_o. One sample is buffered ahead (shadow) so
//               periods run back-to-back without gaps.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                in   1      clock
//   rst_n              in   1      asynchronous active-low reset
//   wfg_axis_tdata_i   in   32     sample; duty = tdata[CNT_W-1:0]
//   wfg_axis_tvalid_i  in   1      sample valid
//   wfg_axis_tready_o  out  1      ready to accept a sample
//   ctrl_en_q_i        in   1      enable; 0 stops, flushes and idles
//   period_q_i         in   CNT_W  PWM period = period_q_i + 1 cycles (live)
//   pol_q_i            in   1      output polarity / idle level
//   pwm_o              out  1      PWM output
//   busy_o             out  1      high while a PWM period is running
//   underrun_o         out  1      one-cycle pulse: boundary with no new sample
// ============================================================================
module wfg_drive_pwm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      wfg_axis_tdata_i,
  input  logic             wfg_axis_tvalid_i,
  output logic             wfg_axis_tready_o,
  input  logic             ctrl_en_q_i,
  input  logic [CNT_W-1:0] period_q_i,
  input  logic             pol_q_i,
  output logic             pwm_o,
  output logic             busy_o,
  output logic             underrun_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_duty_cur;
  logic [CNT_W-1:0] r_shadow;
  logic             r_shadow_vld;
  logic             r_underrun;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_duty_nxt;
  logic [CNT_W-1:0] w_shadow_nxt;
  logic             w_shadow_vld_nxt;
  logic             w_underrun_nxt;

  logic             w_ready;
  logic             w_take;
  logic             w_wrap;
  logic [CNT_W-1:0] w_sample;

  // Only the low CNT_W bits of a sample carry the duty; the rest are ignored.
  logic             w_unused_tdata;
  assign w_unused_tdata = ^wfg_axis_tdata_i[31:CNT_W];

  assign w_sample = wfg_axis_tdata_i[CNT_W-1:0];
  assign w_ready  = ctrl_en_q_i && (r_state != ST_IDLE) && !r_shadow_vld;
  assign w_take   = w_ready && wfg_axis_tvalid_i;
  // '>=' rather than '==' so a period shrunk below the current count wraps
  // at once instead of running the counter all the way round.
  assign w_wrap   = (r_cnt >= period_q_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_duty_cur   <= '0;
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_duty_cur   <= w_duty_nxt;
      r_shadow     <= w_shadow_nxt;
      r_shadow_vld <= w_shadow_vld_nxt;
      r_underrun   <= w_underrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_duty_nxt       = r_duty_cur;
    w_shadow_nxt     = r_shadow;
    w_shadow_vld_nxt = r_shadow_vld;
    w_underrun_nxt   = 1'b0;

    if (!ctrl_en_q_i) begin
      // Disable flushes any buffered sample so it is never replayed later.
      w_state_nxt      = ST_IDLE;
      w_cnt_nxt        = '0;
      w_shadow_vld_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (r_shadow_vld) begin
            w_duty_nxt       = r_shadow;
            w_shadow_vld_nxt = 1'b0;
            w_cnt_nxt        = '0;
            w_state_nxt      = ST_RUN;
          end else if (w_take) begin
            w_shadow_nxt     = w_sample;
            w_shadow_vld_nxt = 1'b1;
          end
        end
        ST_RUN: begin
          if (w_wrap) begin
            w_cnt_nxt = '0;
            if (r_shadow_vld) begin
              w_duty_nxt       = r_shadow;
              w_shadow_vld_nxt = 1'b0;
            end else if (w_take) begin
              // Sample arrives exactly on the boundary: use it straight away.
              w_duty_nxt = w_sample;
            end else begin
              // Nothing new: repeat the last duty and flag it.
              w_underrun_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_take) begin
              w_shadow_nxt     = w_sample;
              w_shadow_vld_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign wfg_axis_tready_o = w_ready;
  assign busy_o            = (r_state == ST_RUN);
  assign underrun_o        = r_underrun;
  // Duty above the period never reaches cnt, so the output saturates active.
  assign pwm_o             = ((r_state == ST_RUN) && (r_cnt < r_duty_cur)) ^ pol_q_i;

endmodule
`default_nettype wire

// File: tb/tb_wfg_drive_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_wfg_drive_pwm
// Description : Self-checking bench for wfg_drive_pwm: reset check, a vector
//               table, hand-written corner sequences and a randomized run
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wfg_drive_pwm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        en;
  logic [15:0] period;
  logic        pol;
  logic        pwm;
  logic        busy;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  wfg_drive_pwm #(.CNT_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wfg_axis_tdata_i  (tdata),
    .wfg_axis_tvalid_i (tvalid),
    .wfg_axis_tready_o (tready),
    .ctrl_en_q_i       (en),
    .period_q_i        (period),
    .pol_q_i           (pol),
    .pwm_o             (pwm),
    .busy_o            (busy),
    .underrun_o        (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        valid;
    logic [31:0] data;
    logic [15:0] period;
    logic        pol;
    logic        e_tready;
    logic        e_pwm;
    logic        e_busy;
    logic        e_ur;
  } vec_t;

  vec_t tbl [14];

  // Behavioural model: "running" means a period is being played, "waiting"
  // means enabled but no duty loaded yet; pending holds the buffered sample.
  bit   m_run, m_wait, m_ur;
  int   m_phase, m_duty;
  int   m_pend [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    en     = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    pol    = 1'b0;
    period = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_run = 0; m_wait = 0; m_ur = 0; m_phase = 0; m_duty = 0;
    m_pend.delete();
  endtask

  // Returns at the first negedge where busy is high (first cycle of a period).
  task automatic wait_busy(input string nm);
    bit seen;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: busy never rose within 30 cycles", nm);
    end
  endtask

  task automatic model_step();
    bit take;
    take = en && (m_run || m_wait) && (m_pend.size() == 0) && tvalid;
    m_ur = 0;
    if (!en) begin
      m_run = 0; m_wait = 0; m_phase = 0;
      m_pend.delete();
    end else if (!m_run && !m_wait) begin
      m_wait = 1;
    end else if (m_wait) begin
      if (m_pend.size() > 0) begin
        m_duty = m_pend.pop_front();
        m_phase = 0; m_wait = 0; m_run = 1;
      end else if (take) begin
        m_pend.push_back(int'(tdata % 65536));
      end
    end else begin
      if (m_phase >= int'(period)) begin
        m_phase = 0;
        if (m_pend.size() > 0) m_duty = m_pend.pop_front();
        else if (take)         m_duty = int'(tdata % 65536);
        else                   m_ur = 1;
      end else begin
        m_phase++;
        if (take) m_pend.push_back(int'(tdata % 65536));
      end
    end
  endtask

  initial begin
    int h;
    logic [7:0] pat;
    bit e_rdy, e_pwm;

    // Underrun / latency table, period 4, one sample of duty 2.
    tbl[0]  = '{1, 0, 32'h0,         16'd4, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 32'hDEAD_0002, 16'd4, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 32'h0,         16'd4, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 32'h0,         16'd4, 0, 1, 1, 1, 0};
    tbl[4]  = '{1, 0, 32'h0,         16'd4, 0, 1, 1, 1, 0};
    tbl[5]  = '{1, 0, 32'h0,         16'd4, 0, 1, 0, 1, 0};
    tbl[6]  = '{1, 0, 32'h0,         16'd4, 0, 1, 0, 1, 0};
    tbl[7]  = '{1, 0, 32'h0,         16'd4, 0, 1, 0, 1, 0};
    tbl[8]  = '{1, 0, 32'h0,         16'd4, 0, 1, 1, 1, 1};
    tbl[9]  = '{1, 0, 32'h0,         16'd4, 0, 1, 1, 1, 0};
    tbl[10] = '{1, 0, 32'h0,         16'd4, 0, 1, 0, 1, 0};
    tbl[11] = '{1, 0, 32'h0,         16'd4, 0, 1, 0, 1, 0};
    tbl[12] = '{1, 0, 32'h0,         16'd4, 0, 1, 0, 1, 0};
    tbl[13] = '{1, 0, 32'h0,         16'd4, 0, 1, 1, 1, 1};

    // T1: reset state with valid and enable asserted.
    rst_n = 1'b0; en = 1'b1; tvalid = 1'b1; tdata = 32'd5; pol = 1'b0; period = 16'd9;
    repeat (2) @(negedge clk);
    chk("t1_tready", tready, 0);
    chk("t1_pwm", pwm, 0);
    chk("t1_busy", busy, 0);
    chk("t1_underrun", underrun, 0);

    // T3 table.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      en = tbl[i].en; tvalid = tbl[i].valid; tdata = tbl[i].data;
      period = tbl[i].period; pol = tbl[i].pol;
      #1;
      chk($sformatf("tbl%0d_tready", i), tready, tbl[i].e_tready);
      chk($sformatf("tbl%0d_pwm", i), pwm, tbl[i].e_pwm);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_underrun", i), underrun, tbl[i].e_ur);
    end

    // T2: period 9, samples 3 then 7 back-to-back.
    do_reset();
    en = 1; tvalid = 1; tdata = 32'd3; period = 16'd9;
    @(negedge clk);
    chk("t2_tready_wait", tready, 1);
    @(negedge clk);
    chk("t2_pwm_before_run", pwm, 0);
    tdata = 32'd7;
    @(negedge clk);
    chk("t2_busy_first", busy, 1);
    chk("t2_first_high", pwm, 1);
    h = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      h += int'(pwm);
    end
    chk("t2_duty3_count", h, 3);
    h = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      h += int'(pwm);
    end
    chk("t2_duty7_count", h, 7);

    // T4: duty 0 and saturated duty, both polarities.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      pol = s[0];
      en = 1; tvalid = 1; period = 16'd9;
      tdata = s[1] ? 32'hABCD_FFFF : 32'h1234_0000;
      wait_busy("t4_start");
      h = 0;
      for (int i = 0; i < 10; i++) begin
        if (i > 0) @(negedge clk);
        h += int'(pwm ^ pol);
      end
      chk($sformatf("t4_active_count_s%0d", s), h, s[1] ? 10 : 0);
    end

    // T5: bypass at the boundary with an empty shadow.
    do_reset();
    en = 1; tvalid = 1; tdata = 32'd2; period = 16'd4;
    @(negedge clk);
    @(negedge clk);
    tvalid = 0;
    wait_busy("t5_start");
    repeat (4) @(negedge clk);
    tvalid = 1; tdata = 32'd4;
    #1;
    chk("t5_tready_at_boundary", tready, 1);
    @(negedge clk);
    tvalid = 0;
    chk("t5_no_underrun", underrun, 0);
    h = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      h += int'(pwm);
    end
    chk("t5_bypass_duty", h, 4);
    @(negedge clk);
    chk("t5_shadow_empty_underrun", underrun, 1);

    // T6: disable mid-run with a full shadow, pol=1.
    do_reset();
    pol = 1; en = 1; tvalid = 1; tdata = 32'd3; period = 16'd9;
    @(negedge clk);
    @(negedge clk);
    tdata = 32'd8;
    @(negedge clk);
    chk("t6_busy", busy, 1);
    repeat (5) @(negedge clk);
    chk("t6_shadow_full", tready, 0);
    en = 0; tvalid = 0;
    @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_pwm", pwm, 1);
    chk("t6_idle_tready", tready, 0);
    en = 1;
    repeat (4) @(negedge clk);
    chk("t6_no_replay_busy", busy, 0);
    chk("t6_wait_tready", tready, 1);
    tvalid = 1; tdata = 32'd5;
    wait_busy("t6_restart");
    h = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      h += int'(pwm ^ pol);
    end
    chk("t6_new_duty", h, 5);

    // T7: period shrinks 20 -> 3 while the count is 10.
    do_reset();
    en = 1; tvalid = 1; tdata = 32'd15; period = 16'd20;
    @(negedge clk);
    @(negedge clk);
    tdata = 32'd2;
    wait_busy("t7_start");
    repeat (10) @(negedge clk);
    chk("t7_pwm_before", pwm, 1);
    period = 16'd3;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat = {pat[6:0], pwm};
    end
    chk("t7_shrink_pattern", pat, 8'b1100_1100);

    // T8: asynchronous reset in the middle of an active phase.
    do_reset();
    en = 1; tvalid = 1; tdata = 32'd5; period = 16'd9;
    wait_busy("t8_start");
    #2 rst_n = 1'b0;
    #1;
    chk("t8_async_pwm", pwm, 0);
    chk("t8_async_busy", busy, 0);
    chk("t8_async_tready", tready, 0);

    // Randomized run against the model.
    do_reset();
    period = 16'd5;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en     = ($urandom % 64) != 0;
      tvalid = ($urandom % 3) != 0;
      tdata  = {$urandom} & 32'hFFFF_0000;
      tdata[15:0] = (($urandom % 10) == 0) ? 16'hFFFF : 16'($urandom_range(0, 14));
      if (($urandom % 50) == 0) period = 16'($urandom_range(0, 12));
      if (($urandom % 200) == 0) pol = ~pol;
      #1;
      e_rdy = en && (m_run || m_wait) && (m_pend.size() == 0);
      e_pwm = (m_run && (m_phase < m_duty)) ^ pol;
      chk("rnd_tready", tready, e_rdy);
      chk("rnd_pwm", pwm, e_pwm);
      chk("rnd_busy", busy, m_run);
      chk("rnd_underrun", underrun, m_ur);
      @(posedge clk);
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
